// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution tile sequencer and its feed counter.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FEED   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] FEED_FULL   = 2'd0;
    localparam logic [1:0] FEED_COL    = 2'd1;
    localparam logic [1:0] FEED_ROW    = 2'd2;
    localparam logic [1:0] FEED_SINGLE = 2'd3;

    localparam int PARA_X_DEF = 3;
    localparam int PARA_Y_DEF = 3;

    localparam int KSIZE_3 = 3;
    localparam int KSIZE_5 = 5;

    // Window position to feed shape: first element loads the whole block, first row
    // shifts in a column per group, first column shifts a row into the last group.
    function automatic logic [1:0] feed_type_f(input int kx, input int ky);
        logic [1:0] t;
        if (kx == 0 && ky == 0) begin
            t = FEED_FULL;
        end else if (ky == 0) begin
            t = FEED_COL;
        end else if (kx == 0) begin
            t = FEED_ROW;
        end else begin
            t = FEED_SINGLE;
        end
        return t;
    endfunction

endpackage

// File: rtl/conv_feed_counter.sv
// Walks the K x K kernel window and produces registered feed descriptors per cycle.
module conv_feed_counter
    import conv_pkg::*;
#(
    parameter int DIM_WIDTH         = 8,
    parameter int KERNEL_SIZE_WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic                           advance,
    input  logic [KERNEL_SIZE_WIDTH-1:0]   k,
    input  logic [DIM_WIDTH-1:0]           row_base,
    input  logic [DIM_WIDTH-1:0]           col_base,
    output logic [DIM_WIDTH-1:0]           feed_row,
    output logic [DIM_WIDTH-1:0]           feed_col,
    output logic [2*KERNEL_SIZE_WIDTH-1:0] weight_addr,
    output logic [1:0]                     feed_type,
    output logic                           last
);

    logic [KERNEL_SIZE_WIDTH-1:0]   kx_r, ky_r, kx_n, ky_n;
    logic [2*KERNEL_SIZE_WIDTH-1:0] c_r;
    logic [DIM_WIDTH-1:0]           row_r, col_r, base_col_r;
    logic [1:0]                     type_r, type_n;
    logic                           kx_wrap_s;

    assign kx_wrap_s = (kx_r == (k - KERNEL_SIZE_WIDTH'(1)));
    assign last      = kx_wrap_s && (ky_r == (k - KERNEL_SIZE_WIDTH'(1)));

    // Next window position and the feed shape that goes with it.
    always_comb begin
        kx_n   = kx_r;
        ky_n   = ky_r;
        type_n = type_r;
        if (kx_wrap_s) begin
            kx_n = '0;
            ky_n = ky_r + KERNEL_SIZE_WIDTH'(1);
        end else begin
            kx_n = kx_r + KERNEL_SIZE_WIDTH'(1);
        end
        type_n = feed_type_f(int'(kx_n), int'(ky_n));
    end

    // Window counters; weight address equals the linear counter ky*K+kx.
    always_ff @(posedge clk) begin
        if (rst) begin
            kx_r       <= '0;
            ky_r       <= '0;
            c_r        <= '0;
            row_r      <= '0;
            col_r      <= '0;
            base_col_r <= '0;
            type_r     <= FEED_FULL;
        end else if (load) begin
            kx_r       <= '0;
            ky_r       <= '0;
            c_r        <= '0;
            row_r      <= row_base;
            col_r      <= col_base;
            base_col_r <= col_base;
            type_r     <= FEED_FULL;
        end else if (advance) begin
            kx_r   <= kx_n;
            ky_r   <= ky_n;
            c_r    <= c_r + (2*KERNEL_SIZE_WIDTH)'(1);
            type_r <= type_n;
            row_r  <= kx_wrap_s ? row_r + DIM_WIDTH'(1) : row_r;
            col_r  <= kx_wrap_s ? base_col_r : col_r + DIM_WIDTH'(1);
        end
    end

    assign feed_row    = row_r;
    assign feed_col    = col_r;
    assign weight_addr = c_r;
    assign feed_type   = type_r;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Tile-by-tile layer sequencer for the PARA_X x PARA_Y conv datapath.
// Optional WAIT watchdog with sticky wdog_err enabled by CONV_SEQ_WDOG_EN.
module conv_tile_sequencer
    import conv_pkg::*;
#(
    parameter int PARA_X            = PARA_X_DEF,
    parameter int PARA_Y            = PARA_Y_DEF,
    parameter int DIM_WIDTH         = 8,
    parameter int KERNEL_SIZE_WIDTH = 6
`ifdef CONV_SEQ_WDOG_EN
    ,parameter int WDOG_LIMIT       = 256
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]   kernel_size,
    input  logic [DIM_WIDTH-1:0]           fm_width,
    input  logic [DIM_WIDTH-1:0]           fm_height,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err,
    output logic                           feed_valid,
    output logic [1:0]                     feed_type,
    output logic [DIM_WIDTH-1:0]           feed_row,
    output logic [DIM_WIDTH-1:0]           feed_col,
    output logic [2*KERNEL_SIZE_WIDTH-1:0] weight_addr,
    output logic                           dp_rst_n,
    input  logic                           dp_result_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DIM_WIDTH-1:0]           out_row,
    output logic [DIM_WIDTH-1:0]           out_col,
    output logic [DIM_WIDTH-1:0]           out_rows_vld,
    output logic [DIM_WIDTH-1:0]           out_cols_vld
`ifdef CONV_SEQ_WDOG_EN
    ,output logic                          wdog_err
`endif
);

    state_t                         state_r, state_n;
    logic [KERNEL_SIZE_WIDTH-1:0]   k_r;
    logic [DIM_WIDTH-1:0]           oh_r, ow_r, tile_row_r, tile_col_r, tile_row_n, tile_col_n;
    logic [DIM_WIDTH-1:0]           rows_vld_r, cols_vld_r, oh_diff_s, ow_diff_s;
    logic [DIM_WIDTH:0]             row_sum_s, col_sum_s;
    logic                           busy_r, done_r, cfg_err_r, cfg_err_n, feed_valid_r;
    logic                           dp_rst_n_r, out_valid_r, cfg_ok_s, last_tile_s;
    logic                           load_s, advance_s, feed_last_s;
    logic [DIM_WIDTH-1:0]           ksz_s;
`ifdef CONV_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0]              wdog_cnt_r;
    logic                           wdog_hit_s, wdog_err_r;
`endif

    assign ksz_s    = DIM_WIDTH'(kernel_size);
    assign cfg_ok_s = ((kernel_size == KERNEL_SIZE_WIDTH'(KSIZE_3)) ||
                       (kernel_size == KERNEL_SIZE_WIDTH'(KSIZE_5))) &&
                      (fm_width >= ksz_s) && (fm_height >= ksz_s);

    assign row_sum_s = {1'b0, tile_row_r} + (DIM_WIDTH+1)'(PARA_X);
    assign col_sum_s = {1'b0, tile_col_r} + (DIM_WIDTH+1)'(PARA_Y);
    assign oh_diff_s = oh_r - tile_row_r;
    assign ow_diff_s = ow_r - tile_col_r;

    // Next tile origin: raster order over the output map; IDLE launches at (0,0).
    always_comb begin
        tile_row_n  = '0;
        tile_col_n  = '0;
        last_tile_s = 1'b0;
        if (state_r == ST_NEXT) begin
            if (col_sum_s >= {1'b0, ow_r}) begin
                tile_col_n  = '0;
                tile_row_n  = row_sum_s[DIM_WIDTH-1:0];
                last_tile_s = (row_sum_s >= {1'b0, oh_r});
            end else begin
                tile_col_n  = col_sum_s[DIM_WIDTH-1:0];
                tile_row_n  = tile_row_r;
                last_tile_s = 1'b0;
            end
        end else begin
            tile_row_n  = '0;
            tile_col_n  = '0;
            last_tile_s = 1'b0;
        end
    end

    // Next-state logic; starts outside IDLE (including the DONE cycle) are dropped.
    always_comb begin
        state_n   = state_r;
        cfg_err_n = 1'b0;
`ifdef CONV_SEQ_WDOG_EN
        wdog_hit_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok_s) begin
                        state_n = ST_FEED;
                    end else begin
                        cfg_err_n = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (feed_last_s) begin
                    state_n = ST_WAIT;
                end else begin
                    state_n = ST_FEED;
                end
            end
            ST_WAIT: begin
                if (dp_result_ready) begin
                    state_n = ST_OUTPUT;
`ifdef CONV_SEQ_WDOG_EN
                end else if (wdog_cnt_r == WDOG_W'(WDOG_LIMIT - 1)) begin
                    state_n    = ST_DONE;
                    wdog_hit_s = 1'b1;
`endif
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_n = ST_NEXT;
                end else begin
                    state_n = ST_OUTPUT;
                end
            end
            ST_NEXT: begin
                if (last_tile_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_FEED;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign load_s    = (state_n == ST_FEED) && (state_r != ST_FEED);
    assign advance_s = (state_r == ST_FEED) && !feed_last_s;

    // State, registered status outputs, captured layer config and tile bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
            feed_valid_r <= 1'b0;
            dp_rst_n_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            k_r          <= '0;
            oh_r         <= '0;
            ow_r         <= '0;
            tile_row_r   <= '0;
            tile_col_r   <= '0;
            rows_vld_r   <= '0;
            cols_vld_r   <= '0;
        end else begin
            state_r      <= state_n;
            busy_r       <= (state_n != ST_IDLE) && (state_n != ST_DONE);
            done_r       <= (state_n == ST_DONE);
            cfg_err_r    <= cfg_err_n;
            feed_valid_r <= (state_n == ST_FEED);
            dp_rst_n_r   <= (state_n == ST_FEED) || (state_n == ST_WAIT);
            out_valid_r  <= (state_n == ST_OUTPUT);
            if ((state_r == ST_IDLE) && start && cfg_ok_s) begin
                k_r  <= kernel_size;
                oh_r <= fm_height - ksz_s + DIM_WIDTH'(1);
                ow_r <= fm_width - ksz_s + DIM_WIDTH'(1);
            end
            if (load_s) begin
                tile_row_r <= tile_row_n;
                tile_col_r <= tile_col_n;
            end
            if ((state_r == ST_WAIT) && (state_n == ST_OUTPUT)) begin
                rows_vld_r <= (oh_diff_s > DIM_WIDTH'(PARA_X)) ? DIM_WIDTH'(PARA_X) : oh_diff_s;
                cols_vld_r <= (ow_diff_s > DIM_WIDTH'(PARA_Y)) ? DIM_WIDTH'(PARA_Y) : ow_diff_s;
            end
        end
    end

`ifdef CONV_SEQ_WDOG_EN
    // WAIT-cycle watchdog and its sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_r <= '0;
            wdog_err_r <= 1'b0;
        end else begin
            wdog_cnt_r <= (state_r == ST_WAIT) ? wdog_cnt_r + WDOG_W'(1) : '0;
            if (wdog_hit_s) begin
                wdog_err_r <= 1'b1;
            end
        end
    end
    assign wdog_err = wdog_err_r;
`endif

    conv_feed_counter #(
        .DIM_WIDTH         (DIM_WIDTH),
        .KERNEL_SIZE_WIDTH (KERNEL_SIZE_WIDTH)
    ) u_feed_counter (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .advance     (advance_s),
        .k           (k_r),
        .row_base    (tile_row_n),
        .col_base    (tile_col_n),
        .feed_row    (feed_row),
        .feed_col    (feed_col),
        .weight_addr (weight_addr),
        .feed_type   (feed_type),
        .last        (feed_last_s)
    );

    assign busy         = busy_r;
    assign done         = done_r;
    assign cfg_err      = cfg_err_r;
    assign feed_valid   = feed_valid_r;
    assign dp_rst_n     = dp_rst_n_r;
    assign out_valid    = out_valid_r;
    assign out_row      = tile_row_r;
    assign out_col      = tile_col_r;
    assign out_rows_vld = rows_vld_r;
    assign out_cols_vld = cols_vld_r;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Self-checking bench for conv_tile_sequencer: directed layers plus randomized map sizes.
module tb_conv_tile_sequencer;

    localparam int PX = 3;
    localparam int PY = 3;
    localparam int DW = 8;
    localparam int KW = 6;

    logic            clk = 1'b0;
    logic            rst, start, dp_result_ready, out_ready;
    logic [KW-1:0]   kernel_size;
    logic [DW-1:0]   fm_width, fm_height;
    logic            busy, done, cfg_err, feed_valid, dp_rst_n, out_valid;
    logic [1:0]      feed_type;
    logic [DW-1:0]   feed_row, feed_col, out_row, out_col, out_rows_vld, out_cols_vld;
    logic [2*KW-1:0] weight_addr;

    int errors = 0;
    int checks = 0;

    conv_tile_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .kernel_size     (kernel_size),
        .fm_width        (fm_width),
        .fm_height       (fm_height),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .feed_valid      (feed_valid),
        .feed_type       (feed_type),
        .feed_row        (feed_row),
        .feed_col        (feed_col),
        .weight_addr     (weight_addr),
        .dp_rst_n        (dp_rst_n),
        .dp_result_ready (dp_result_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_row         (out_row),
        .out_col         (out_col),
        .out_rows_vld    (out_rows_vld),
        .out_cols_vld    (out_cols_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k, input int w, input int h);
        kernel_size = KW'(k);
        fm_width    = DW'(w);
        fm_height   = DW'(h);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected feed shape from the kernel-window position c.
    function automatic int exp_type(input int c, input int k);
        if (c == 0) return 0;
        if (c < k) return 1;
        if (c % k == 0) return 2;
        return 3;
    endfunction

    // One full layer; the reference tile list is simply the raster walk of the output map.
    task automatic run_layer(input int k, input int w, input int h, input int first_stall);
        int oh, ow, tile_idx, d, stall;
        oh = h - k + 1;
        ow = w - k + 1;
        tile_idx = 0;
        pulse_start(k, w, h);
        check("busy_after_start", int'(busy), 1);
        for (int r = 0; r < oh; r += PX) begin
            for (int cc = 0; cc < ow; cc += PY) begin
                for (int c = 0; c < k * k; c++) begin
                    check("feed_valid", int'(feed_valid), 1);
                    check("feed_dp_rst_n", int'(dp_rst_n), 1);
                    check("feed_type", int'(feed_type), exp_type(c, k));
                    check("feed_row", int'(feed_row), r + c / k);
                    check("feed_col", int'(feed_col), cc + c % k);
                    check("weight_addr", int'(weight_addr), c);
                    tick();
                end
                check("wait_feed_valid", int'(feed_valid), 0);
                check("wait_dp_rst_n", int'(dp_rst_n), 1);
                d = int'($urandom_range(0, 4));
                for (int i = 0; i < d; i++) begin
                    if (i == 0) begin
                        kernel_size = KW'(4);
                        start = 1'b1;
                    end
                    tick();
                    start = 1'b0;
                    check("busy_start_ignored", int'(cfg_err), 0);
                    check("wait_out_valid", int'(out_valid), 0);
                    check("wait_busy", int'(busy), 1);
                end
                dp_result_ready = 1'b1;
                tick();
                dp_result_ready = 1'b0;
                stall = (tile_idx == 0 && first_stall > 0) ? first_stall : int'($urandom_range(0, 3));
                for (int s = 0; s <= stall; s++) begin
                    check("out_valid", int'(out_valid), 1);
                    check("out_dp_rst_n", int'(dp_rst_n), 0);
                    check("out_row", int'(out_row), r);
                    check("out_col", int'(out_col), cc);
                    check("out_rows_vld", int'(out_rows_vld), min2(PX, oh - r));
                    check("out_cols_vld", int'(out_cols_vld), min2(PY, ow - cc));
                    if (s == stall) out_ready = 1'b1;
                    tick();
                    out_ready = 1'b0;
                end
                check("next_out_valid", int'(out_valid), 0);
                check("next_feed_valid", int'(feed_valid), 0);
                check("next_dp_rst_n", int'(dp_rst_n), 0);
                tick();
                tile_idx++;
            end
        end
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 0);
        pulse_start(3, 5, 5);
        check("done_once", int'(done), 0);
        check("start_on_done_ignored_busy", int'(busy), 0);
        check("start_on_done_ignored_feed", int'(feed_valid), 0);
    endtask

    task automatic cfg_reject(input int k, input int w, input int h);
        pulse_start(k, w, h);
        check("cfg_err_pulse", int'(cfg_err), 1);
        check("cfg_err_busy", int'(busy), 0);
        check("cfg_err_feed", int'(feed_valid), 0);
        tick();
        check("cfg_err_once", int'(cfg_err), 0);
        check("cfg_err_busy2", int'(busy), 0);
        check("cfg_err_feed2", int'(feed_valid), 0);
    endtask

    initial begin
        int k, w, h;
        rst = 1'b1;
        start = 1'b0;
        kernel_size = '0;
        fm_width = '0;
        fm_height = '0;
        dp_result_ready = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_feed_valid", int'(feed_valid), 0);
        check("rst_dp_rst_n", int'(dp_rst_n), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_feed_type", int'(feed_type), 0);
        check("rst_feed_row", int'(feed_row), 0);
        check("rst_feed_col", int'(feed_col), 0);
        check("rst_weight_addr", int'(weight_addr), 0);
        check("rst_out_row", int'(out_row), 0);
        check("rst_out_col", int'(out_col), 0);
        check("rst_out_rows_vld", int'(out_rows_vld), 0);
        check("rst_out_cols_vld", int'(out_cols_vld), 0);
        rst = 1'b0;
        tick();

        run_layer(3, 5, 5, 0);
        run_layer(5, 9, 10, 0);
        run_layer(3, 7, 7, 20);
        cfg_reject(4, 8, 8);
        cfg_reject(5, 4, 8);
        cfg_reject(5, 8, 4);

        pulse_start(3, 7, 7);
        for (int i = 0; i < 4; i++) tick();
        check("mid_feed_c4", int'(weight_addr), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_feed_valid", int'(feed_valid), 0);
        check("abort_dp_rst_n", int'(dp_rst_n), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        run_layer(3, 7, 7, 0);

        for (int n = 0; n < 6; n++) begin
            k = ($urandom_range(0, 1) == 1) ? 5 : 3;
            w = int'($urandom_range(k, k + 8));
            h = int'($urandom_range(k, k + 8));
            run_layer(k, w, h, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_tile_sequencer.md
Name: conv_tile_sequencer

Overview:
- Controller that sequences one convolution layer through the PARA_X x PARA_Y float16 conv datapath.
- Walks the output feature map tile by tile, issuing per-cycle feed descriptors (window offset, feed shape, weight address) to the input/weight fetch logic.
- Releases and holds the datapath's active-low reset, waits for its result, then hands each result tile downstream through a valid/ready handshake.
- Sits between the layer-control registers and the datapath plus its fetch units.

Parameters:
- PARA_X, 3, MAC groups (output rows per tile)
- PARA_Y, 3, MACs per group (output cols per tile)
- DIM_WIDTH, 8, width of feature-map dimension and coordinate fields
- KERNEL_SIZE_WIDTH, 6, width of kernel_size
- WDOG_LIMIT, 256, max WAIT cycles (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; launches a layer when idle
- kernel_size  in  KERNEL_SIZE_WIDTH  3 or 5; sampled at start
- fm_width  in  DIM_WIDTH  input map width; sampled at start
- fm_height  in  DIM_WIDTH  input map height; sampled at start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at layer end
- cfg_err  out  1  one-cycle pulse when start is rejected
- feed_valid  out  1  feed descriptor valid this cycle
- feed_type  out  2  0=full block, 1=column per group, 2=row to last group, 3=single element
- feed_row  out  DIM_WIDTH  tile_row+ky
- feed_col  out  DIM_WIDTH  tile_col+kx
- weight_addr  out  2*KERNEL_SIZE_WIDTH  ky*K+kx
- dp_rst_n  out  1  datapath reset, active-low
- dp_result_ready  in  1  datapath result_ready
- out_valid  out  1  result tile available
- out_ready  in  1  downstream accepts tile
- out_row  out  DIM_WIDTH  tile origin row
- out_col  out  DIM_WIDTH  tile origin col
- out_rows_vld  out  DIM_WIDTH  valid rows in tile (1..PARA_X)
- out_cols_vld  out  DIM_WIDTH  valid cols in tile (1..PARA_Y)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: IDLE state; busy, done, cfg_err, feed_valid, out_valid = 0; dp_rst_n = 0; all coordinate and descriptor outputs = 0.
- Derived sizes: OH = fm_height-K+1, OW = fm_width-K+1.
- start rules:
  - Rejected when kernel_size is not 3 or 5, or fm_width < K, or fm_height < K. cfg_err pulses the next cycle; state stays IDLE.
  - Ignored while busy.
- IDLE -> FEED: on an accepted start. Tile origin = (0,0); busy = 1 the following cycle.
- FEED: exactly K*K cycles, counter c = 0..K*K-1, ky = c/K, kx = c%K.
  - dp_rst_n = 1 and feed_valid = 1 every cycle.
  - feed_type: 0 at c=0; 1 for 0<c<K; 2 when c%K==0 and c>0; otherwise 3.
- WAIT: feed_valid = 0, dp_rst_n = 1; leave on dp_result_ready = 1.
- OUTPUT: out_valid = 1 with tile fields; dp_rst_n = 0 so the datapath cannot start the next tile.
  - Fields held stable until the out_valid && out_ready cycle. No drop, no duplicate.
  - Edge tiles: out_rows_vld = min(PARA_X, OH-tile_row); out_cols_vld = min(PARA_Y, OW-tile_col).
- NEXT (1 cycle):
  - tile_col += PARA_Y.
  - If tile_col >= OW: tile_col = 0, tile_row += PARA_X.
  - If tile_row >= OH: go to DONE, else go to FEED.
- DONE: done pulse for 1 cycle, busy = 0, return to IDLE.
- Per-tile latency: 1 (NEXT) + K*K (FEED) + datapath latency + handshake.
- rst asserted in any state: synchronous return to reset values. Any tile in flight is abandoned and dp_rst_n drops the same edge.
- start arriving in the same cycle as done: ignored.

Optional Feature:
- Macro: CONV_SEQ_WDOG_EN.
- When defined: a WAIT-cycle counter aborts the layer once it reaches WDOG_LIMIT without dp_result_ready. Abort sets a sticky wdog_err output (cleared only by rst) and goes to DONE; done still pulses.
- When undefined: no counter, no wdog_err port; WAIT waits indefinitely.

Decomposition:
- Shared package conv_pkg holds:
  - state enum (IDLE, FEED, WAIT, OUTPUT, NEXT, DONE)
  - feed_type codes
  - PARA_X/PARA_Y defaults
  - legal kernel size constants
- One sub-module is natural: conv_feed_counter (kx/ky/c counters plus feed_type decode).

Test Plan:
- K=3, 5x5 map: 1 tile; exactly 9 feed cycles, feed_type sequence 0,1,1,2,3,3,2,3,3; out_rows_vld=3, out_cols_vld=3; done once.
- K=5, 10x9 map: OH=6, OW=5 gives tiles at (0,0),(0,3),(3,0),(3,3); 25 feed cycles each; tile (3,3) reports cols_vld=2.
- K=3, 7x7 map with out_ready held low 20 cycles on the first tile: out fields stable, dp_rst_n=0 throughout, tile accepted exactly once.
- kernel_size=4, or K=5 with fm_width=4: cfg_err pulses once, busy stays 0, no feed_valid.
- rst asserted mid-FEED at c=4: next cycle IDLE, dp_rst_n=0, feed_valid=0; a new start runs normally.
- CONV_SEQ_WDOG_EN defined, dp_result_ready never asserted: wdog_err=1 after 256 WAIT cycles, done pulses, wdog_err held until rst.
